alu_fpga_harness: RTL

ALU_FPGA_HARNESS -- requirements
Module: alu_fpga_harness

---
 rtl/alu_fpga_harness_if.sv | 23 ++
 rtl/alu_fpga_harness.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_harness_if.sv
// Bus between the harness and an external combinational ALU under test.
interface alu_fpga_harness_if #(
   parameter int DW   = 32,
   parameter int OP_W = 4
);
   logic [DW-1:0]   alu_portA;
   logic [DW-1:0]   alu_portB;
   logic [OP_W-1:0] alu_op;
   logic [DW-1:0]   alu_portOut;
   logic            alu_flagZero;
   logic            alu_flagNeg;
   logic            alu_flagOvf;

   modport master (
      output alu_portA, alu_portB, alu_op,
      input  alu_portOut, alu_flagZero, alu_flagNeg, alu_flagOvf
   );

   modport slave (
      input  alu_portA, alu_portB, alu_op,
      output alu_portOut, alu_flagZero, alu_flagNeg, alu_flagOvf
   );
endinterface

// File: rtl/alu_fpga_harness.sv
// Board harness for an ALU: keys/switches load operands and op, execute once or
// sweep all ops, and LEDs page through the result and flags.
module alu_fpga_harness #(
   parameter int DW         = 32,
   parameter int OP_W       = 4,
   parameter int NUM_OPS    = 16,
   parameter int DB_CYC     = 65536,
   parameter int SWEEP_HOLD = 50000000
) (
   input  logic                CLOCK_50,
   input  logic                RST,
   input  logic [3:0]          KEY,
   input  logic [17:0]         SW,
   output logic [17:0]         LEDR,
   output logic [7:0]          LEDG,
   alu_fpga_harness_if.master  alu
);

   localparam int PAGES = DW / 16;
   localparam int DBW   = $clog2(DB_CYC);
   localparam int HW    = (SWEEP_HOLD > 1) ? $clog2(SWEEP_HOLD) : 1;
   localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYC - 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(SWEEP_HOLD - 1);
   localparam logic [OP_W-1:0] OP_LAST   = OP_W'(NUM_OPS - 1);
   localparam logic [1:0]      PAGE_LAST = 2'(PAGES - 1);

   typedef enum logic [2:0] {
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP, ST_EXEC, ST_SHOW, ST_SWEEP
   } state_t;

   logic [3:0]     r_key_s1, r_key_s2, r_db_level, r_press;
   logic [DBW-1:0] r_db_cnt [4];
   logic [3:0]     w_fall;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_a, r_b, r_res;
   logic [OP_W-1:0] r_op;
   logic            r_flag_z, r_flag_n, r_flag_o;
   logic [1:0]      r_page;
   logic [HW-1:0]   r_hold;
   logic [63:0]     w_disp;
   logic            w_clr, w_swp, w_nxt, w_dat, w_hold_end;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         r_key_s1   <= '1;
         r_key_s2   <= '1;
         r_db_level <= '1;
         r_press    <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         r_key_s1 <= KEY;
         r_key_s2 <= r_key_s1;
         r_press  <= w_fall;
         for (int i = 0; i < 4; i++) begin
            if (r_key_s2[i] == r_db_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db_cnt[i]   <= '0;
               r_db_level[i] <= r_key_s2[i];
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_fall = '0;
      for (int i = 0; i < 4; i++)
         w_fall[i] = r_db_level[i] & ~r_key_s2[i] & (r_db_cnt[i] == DB_LAST);
   end

   // Only the highest-priority press of a cycle survives.
   assign w_clr      = r_press[3];
   assign w_swp      = r_press[2] & ~r_press[3];
   assign w_nxt      = r_press[1] & ~|r_press[3:2];
   assign w_dat      = r_press[0] & ~|r_press[3:1];
   assign w_hold_end = (r_hold == HOLD_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (RST) r_state <= ST_LOAD_A;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_clr) begin
         w_state_nxt = ST_LOAD_A;
      end else begin
         case (r_state)
            ST_LOAD_A:  if (w_swp) w_state_nxt = ST_SWEEP; else if (w_nxt) w_state_nxt = ST_LOAD_B;
            ST_LOAD_B:  if (w_swp) w_state_nxt = ST_SWEEP; else if (w_nxt) w_state_nxt = ST_LOAD_OP;
            ST_LOAD_OP: if (w_swp) w_state_nxt = ST_SWEEP; else if (w_nxt) w_state_nxt = ST_EXEC;
            ST_EXEC:    w_state_nxt = ST_SHOW;
            ST_SHOW:    if (w_swp) w_state_nxt = ST_SWEEP; else if (w_nxt) w_state_nxt = ST_LOAD_A;
            ST_SWEEP:   if (w_swp || (w_hold_end && r_op == OP_LAST)) w_state_nxt = ST_SHOW;
            default:    w_state_nxt = ST_LOAD_A;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RST || w_clr) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_res    <= '0;
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
         r_flag_o <= 1'b0;
         r_page   <= '0;
         r_hold   <= '0;
      end else begin
         if (w_state_nxt != r_state)
            r_page <= '0;
         else if (r_state == ST_SHOW && w_dat)
            r_page <= (r_page == PAGE_LAST) ? 2'd0 : r_page + 2'd1;

         case (r_state)
            ST_LOAD_A:  if (w_dat) r_a  <= (r_a << 16) | DW'(SW[15:0]);
            ST_LOAD_B:  if (w_dat) r_b  <= (r_b << 16) | DW'(SW[15:0]);
            ST_LOAD_OP: if (w_dat) r_op <= SW[OP_W-1:0];
            ST_EXEC: begin
               r_res    <= alu.alu_portOut;
               r_flag_z <= alu.alu_flagZero;
               r_flag_n <= alu.alu_flagNeg;
               r_flag_o <= alu.alu_flagOvf;
            end
            ST_SWEEP: begin
               if (!w_swp) begin
                  if (w_hold_end) begin
                     r_hold   <= '0;
                     r_res    <= r_res ^ alu.alu_portOut;
                     r_flag_z <= r_flag_z | alu.alu_flagZero;
                     r_flag_n <= r_flag_n | alu.alu_flagNeg;
                     r_flag_o <= r_flag_o | alu.alu_flagOvf;
                     if (r_op != OP_LAST) r_op <= r_op + OP_W'(1);
                  end else begin
                     r_hold <= r_hold + HW'(1);
                  end
               end
            end
            default: ;
         endcase

         if (r_state != ST_SWEEP && w_state_nxt == ST_SWEEP) begin
            r_op     <= '0;
            r_res    <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_o <= 1'b0;
            r_hold   <= '0;
         end
      end
   end

   always_comb begin
      w_disp = '0;
      case (r_state)
         ST_LOAD_A:  w_disp[DW-1:0]   = r_a;
         ST_LOAD_B:  w_disp[DW-1:0]   = r_b;
         ST_LOAD_OP: w_disp[OP_W-1:0] = r_op;
         default:    w_disp[DW-1:0]   = r_res;
      endcase
   end

   assign alu.alu_portA = r_a;
   assign alu.alu_portB = r_b;
   assign alu.alu_op    = r_op;

   assign LEDR = {r_page, w_disp[{r_page, 4'b0000} +: 16]};
   assign LEDG = {4'(r_op), (r_state == ST_SWEEP), r_flag_o, r_flag_n, r_flag_z};

   wire w_unused = &{1'b0, SW[17:16]};

endmodule
